axi_cfg_master: RTL and testbench
=================================

# axi_cfg_master

AXI4-Lite initiator that turns single-word read/write commands into complete AXI4-Lite transactions and returns the response. It sits between a local command source (the host-side test sequencer or a DFR configuration loader) and the DFR configuration register slave. It handles one outstanding transaction at a time and has a programmable timeout.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 32, data width; must be 32.
- C_M_AXI_ADDR_WIDTH, 9, address width.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  the single clock.
- M_AXI_ARESET  in  1  reset: asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI response code, or 2'b10 on timeout.
- rsp_timeout  out  1  high when the transaction was aborted by timeout.
- M_AXI_AWADDR / AWVALID / AWREADY: out / out / in; widths ADDR / 1 / 1.
- M_AXI_AWPROT  out  3  tied to 3'b000.
- M_AXI_WDATA / WSTRB / WVALID / WREADY: out / out / out / in.
- M_AXI_BRESP / BVALID / BREADY: in 2 / in 1 / out 1.
- M_AXI_ARADDR / ARVALID / ARREADY: out / out / in.
- M_AXI_ARPROT  out  3  tied to 3'b000.
- M_AXI_RDATA / RRESP / RVALID / RREADY: in / in / in / out.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, capture addr, wdata and wstrb into holding registers.
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together.
  - Each one deasserts independently the cycle after its own handshake and is never re-raised.
  - When both handshakes are complete, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID: capture BRESP, pulse rsp_valid, set rsp_rdata=0, go to IDLE.
- RD_REQ:
  - ARVALID=1.
  - On ARREADY, go to RD_RESP.
- RD_RESP:
  - RREADY=1.
  - On RVALID: capture RDATA and RRESP, pulse rsp_valid, go to IDLE.
- AW/W ordering:
  - AW and W may complete in either order or in the same cycle.
  - BVALID arriving before both handshakes complete is ignored; BREADY stays 0.
- Timeout:
  - A counter clears on command accept and increments every non-IDLE cycle.
  - When it reaches TIMEOUT_CYCLES:
    - all VALID/READY outputs drop;
    - rsp_valid pulses with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0;
    - the FSM returns to IDLE.
  - After a timeout the slave must be reset by the system.
  - When completion and timeout occur in the same cycle, completion wins.
- Address/data outputs are driven from the holding registers and stay stable while their VALID is high.
- cmd_* inputs are ignored outside IDLE.

## Timing
- All outputs are registered.
- Reset values: state IDLE, cmd_ready=1; all VALID/READY outputs, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata and address/data outputs 0.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous); no response is emitted.
- Write latency, zero-wait slave (AWREADY, WREADY, BVALID all high):
  - command accepted at cycle 0;
  - AW/W handshake at cycle 1;
  - BREADY high at cycle 2, B handshake at cycle 2;
  - rsp_valid at cycle 3;
  - cmd_ready high again at cycle 3.
- Read latency, zero-wait slave: AR handshake at cycle 1, R handshake at cycle 2, rsp_valid at cycle 3.
- Back-to-back throughput: one transaction per 3 cycles minimum. A new command can be accepted in the same cycle rsp_valid is high.
- rsp_* fields hold their values until the next response; rsp_valid is high for exactly 1 cycle.

## Test plan
- Write 0x0000_0005 to 0x014 with a zero-wait slave → AWVALID and WVALID high at cycle 1; rsp_valid at cycle 3 with rsp_resp=00; slave register 0x014 reads back 5.
- Write with WREADY delayed 4 cycles after AWREADY → AWVALID drops after 1 cycle, WVALID is held 5 cycles, BREADY rises only afterwards; a single rsp_valid.
- Read 0x008 where the slave returns 0xDEAD_BEEF with RVALID delayed 3 cycles → rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_valid at cycle 6.
- TIMEOUT_CYCLES=8, slave never raises ARREADY → ARVALID drops after 8 cycles, rsp_valid with rsp_resp=10, rsp_timeout=1, cmd_ready=1 the next cycle.
- Slave returns BRESP=2'b10 → rsp_resp=10, rsp_timeout=0.
- Assert M_AXI_ARESET during RD_RESP → all outputs reset asynchronously, no rsp_valid; a subsequent read completes normally.

Source files
------------

// File: rtl/axi_cfg_master_if.sv
// AXI4-Lite bus bundle between the configuration initiator and the register slave.
// The master modport is the initiator side; the slave modport mirrors it.
`timescale 1ns/1ps
interface axi_cfg_master_if #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9
);
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                      M_AXI_AWPROT;
  logic                            M_AXI_AWVALID;
  logic                            M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                            M_AXI_WVALID;
  logic                            M_AXI_WREADY;
  logic [1:0]                      M_AXI_BRESP;
  logic                            M_AXI_BVALID;
  logic                            M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                      M_AXI_ARPROT;
  logic                            M_AXI_ARVALID;
  logic                            M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                      M_AXI_RRESP;
  logic                            M_AXI_RVALID;
  logic                            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: turns one read/write command into a full
// bus transaction and returns a one-cycle response, with an optional cycle timeout.
`timescale 1ns/1ps
module axi_cfg_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  axi_cfg_master_if.master                m_axi
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  // Timer counts 0..TIMEOUT_CYCLES-1; the abort fires on the cycle it would reach the limit.
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMR_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             aw_fin;
  logic             w_fin;
  logic             resp_done;
  logic             tmo_hit;

  assign m_axi.M_AXI_AWPROT = 3'b000;
  assign m_axi.M_AXI_ARPROT = 3'b000;

  // A channel counts as finished once its VALID has dropped or is being accepted now.
  assign aw_fin    = !m_axi.M_AXI_AWVALID || m_axi.M_AXI_AWREADY;
  assign w_fin     = !m_axi.M_AXI_WVALID  || m_axi.M_AXI_WREADY;
  assign resp_done = ((state == WR_RESP) && m_axi.M_AXI_BVALID) ||
                     ((state == RD_RESP) && m_axi.M_AXI_RVALID);
  assign tmo_hit   = TMR_EN && (timer == TMR_LAST);

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state               <= IDLE;
      timer               <= '0;
      cmd_ready           <= 1'b1;
      rsp_valid           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_resp            <= 2'b00;
      rsp_timeout         <= 1'b0;
      m_axi.M_AXI_AWADDR  <= '0;
      m_axi.M_AXI_AWVALID <= 1'b0;
      m_axi.M_AXI_WDATA   <= '0;
      m_axi.M_AXI_WSTRB   <= '0;
      m_axi.M_AXI_WVALID  <= 1'b0;
      m_axi.M_AXI_BREADY  <= 1'b0;
      m_axi.M_AXI_ARADDR  <= '0;
      m_axi.M_AXI_ARVALID <= 1'b0;
      m_axi.M_AXI_RREADY  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            m_axi.M_AXI_AWADDR <= cmd_addr;
            m_axi.M_AXI_ARADDR <= cmd_addr;
            m_axi.M_AXI_WDATA  <= cmd_wdata;
            m_axi.M_AXI_WSTRB  <= cmd_wstrb;
            timer              <= '0;
            cmd_ready          <= 1'b0;
            if (cmd_write) begin
              state               <= WR_REQ;
              m_axi.M_AXI_AWVALID <= 1'b1;
              m_axi.M_AXI_WVALID  <= 1'b1;
            end else begin
              state               <= RD_REQ;
              m_axi.M_AXI_ARVALID <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (m_axi.M_AXI_AWREADY) m_axi.M_AXI_AWVALID <= 1'b0;
          if (m_axi.M_AXI_WREADY)  m_axi.M_AXI_WVALID  <= 1'b0;
          if (aw_fin && w_fin) begin
            state              <= WR_RESP;
            m_axi.M_AXI_BREADY <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            state              <= IDLE;
            m_axi.M_AXI_BREADY <= 1'b0;
            cmd_ready          <= 1'b1;
            rsp_valid          <= 1'b1;
            rsp_resp           <= m_axi.M_AXI_BRESP;
            rsp_rdata          <= '0;
            rsp_timeout        <= 1'b0;
          end
        end
        RD_REQ: begin
          if (m_axi.M_AXI_ARREADY) begin
            state               <= RD_RESP;
            m_axi.M_AXI_ARVALID <= 1'b0;
            m_axi.M_AXI_RREADY  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (m_axi.M_AXI_RVALID) begin
            state              <= IDLE;
            m_axi.M_AXI_RREADY <= 1'b0;
            cmd_ready          <= 1'b1;
            rsp_valid          <= 1'b1;
            rsp_resp           <= m_axi.M_AXI_RRESP;
            rsp_rdata          <= m_axi.M_AXI_RDATA;
            rsp_timeout        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: with non-blocking assignments the last one in the block wins, so this
      // abort cleanly overrides whatever the state branch scheduled above.
      if (state != IDLE) begin
        timer <= timer + 1'b1;
        if (tmo_hit && !resp_done) begin
          state               <= IDLE;
          m_axi.M_AXI_AWVALID <= 1'b0;
          m_axi.M_AXI_WVALID  <= 1'b0;
          m_axi.M_AXI_BREADY  <= 1'b0;
          m_axi.M_AXI_ARVALID <= 1'b0;
          m_axi.M_AXI_RREADY  <= 1'b0;
          cmd_ready           <= 1'b1;
          rsp_valid           <= 1'b1;
          rsp_resp            <= 2'b10;
          rsp_rdata           <= '0;
          rsp_timeout         <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_cfg_master.sv
// Directed bench for axi_cfg_master: reactive AXI4-Lite register slave with per-channel
// delays, per-cycle traces of the bus handshake signals, and hand-computed expectations.
`timescale 1ns/1ps
module tb_axi_cfg_master;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid, rsp_timeout;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;

  axi_cfg_master_if #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) bus ();

  axi_cfg_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m_axi       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave configuration, written by the stimulus process only.
  int         aw_delay, w_delay, b_delay, ar_delay, r_delay;
  bit         ar_never, r_force;
  logic [31:0] r_force_data;
  logic [1:0] b_resp_cfg;

  // Slave state, written by the slave process only.
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit          aw_got, w_got, ar_got, b_fire, r_fire;
  logic [8:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] regs [128];

  // NOTE: the slave reacts on the falling edge so its outputs never race the DUT's
  // rising-edge sampling; blocking assignments are therefore safe here.
  always @(negedge clk) begin
    if (rst) begin
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0;  bus.M_AXI_BRESP = 2'b00;
      bus.M_AXI_RVALID = 1'b0;  bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RDATA = '0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    end else begin
      if (b_fire) begin bus.M_AXI_BVALID = 1'b0; aw_got = 0; w_got = 0; b_wait = 0; end
      if (r_fire) begin bus.M_AXI_RVALID = 1'b0; ar_got = 0; r_wait = 0; end
      // B and R are evaluated before AW/W/AR so a response never precedes its request.
      if (aw_got && w_got && !bus.M_AXI_BVALID) begin
        if (b_wait >= b_delay) begin
          for (int i = 0; i < 4; i++)
            if (wr_strb[i]) regs[wr_addr[8:2]][8*i +: 8] = wr_data[8*i +: 8];
          bus.M_AXI_BVALID = 1'b1;
          bus.M_AXI_BRESP  = b_resp_cfg;
        end else b_wait++;
      end
      b_fire = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
      if (ar_got && !bus.M_AXI_RVALID) begin
        if (r_wait >= r_delay) begin
          bus.M_AXI_RVALID = 1'b1;
          bus.M_AXI_RDATA  = r_force ? r_force_data : regs[rd_addr[8:2]];
          bus.M_AXI_RRESP  = 2'b00;
        end else r_wait++;
      end
      r_fire = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
      if (bus.M_AXI_AWVALID && !aw_got) begin
        bus.M_AXI_AWREADY = (aw_wait >= aw_delay); aw_wait++;
      end else begin bus.M_AXI_AWREADY = 1'b0; aw_wait = 0; end
      if (bus.M_AXI_AWREADY) begin aw_got = 1; wr_addr = bus.M_AXI_AWADDR; end
      if (bus.M_AXI_WVALID && !w_got) begin
        bus.M_AXI_WREADY = (w_wait >= w_delay); w_wait++;
      end else begin bus.M_AXI_WREADY = 1'b0; w_wait = 0; end
      if (bus.M_AXI_WREADY) begin w_got = 1; wr_data = bus.M_AXI_WDATA; wr_strb = bus.M_AXI_WSTRB; end
      if (bus.M_AXI_ARVALID && !ar_got && !ar_never) begin
        bus.M_AXI_ARREADY = (ar_wait >= ar_delay); ar_wait++;
      end else begin bus.M_AXI_ARREADY = 1'b0; ar_wait = 0; end
      if (bus.M_AXI_ARREADY) begin ar_got = 1; rd_addr = bus.M_AXI_ARADDR; end
    end
  end

  // Per-cycle traces: bit k holds the signal during cycle k after command accept.
  logic [15:0] tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_rdy;
  int          rsp_cycle, rsp_count;
  logic [31:0] rsp_d;
  logic [1:0]  rsp_r;
  logic        rsp_t;

  // Called at the falling edge of cycle 0; returns at the falling edge of cycle 1.
  task automatic start_cmd(input logic wr, input logic [8:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic trace(input int n);
    tr_aw = '0; tr_w = '0; tr_b = '0; tr_ar = '0; tr_r = '0; tr_rdy = '0;
    rsp_cycle = -1; rsp_count = 0; rsp_d = '0; rsp_r = '0; rsp_t = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clk);
      tr_aw[k] = bus.M_AXI_AWVALID; tr_w[k] = bus.M_AXI_WVALID; tr_b[k] = bus.M_AXI_BREADY;
      tr_ar[k] = bus.M_AXI_ARVALID; tr_r[k] = bus.M_AXI_RREADY; tr_rdy[k] = cmd_ready;
      if (rsp_valid) begin
        rsp_count++;
        if (rsp_cycle < 0) begin
          rsp_cycle = k; rsp_d = rsp_rdata; rsp_r = rsp_resp; rsp_t = rsp_timeout;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    ar_never = 0; r_force = 0; r_force_data = '0; b_resp_cfg = 2'b00;
    repeat (2) @(negedge clk);

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                         bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_addr", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 0);
    check("rst_wdata", bus.M_AXI_WDATA, 0);
    check("prot", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write of 5 to 0x014.
    start_cmd(1'b1, 9'h014, 32'h0000_0005, 4'hF);
    check("wr0_awaddr", bus.M_AXI_AWADDR, 32'h014);
    check("wr0_wdata", bus.M_AXI_WDATA, 32'h5);
    check("wr0_wstrb", bus.M_AXI_WSTRB, 32'hF);
    trace(4);
    check("wr0_awvalid", tr_aw, 16'h0002);
    check("wr0_wvalid", tr_w, 16'h0002);
    check("wr0_bready", tr_b, 16'h0004);
    check("wr0_rsp_cycle", rsp_cycle, 3);
    check("wr0_rsp_count", rsp_count, 1);
    check("wr0_resp", {rsp_t, rsp_r}, 0);
    check("wr0_cmd_ready", tr_rdy, 16'h0018);

    // Zero-wait read back of 0x014, then a write accepted in the response cycle.
    start_cmd(1'b0, 9'h014, '0, '0);
    trace(2);
    check("rd0_arvalid", tr_ar, 16'h0002);
    check("rd0_rready", tr_r, 16'h0004);
    @(negedge clk);
    check("rd0_rsp_valid", rsp_valid, 1);
    check("rd0_rdata", rsp_rdata, 32'h5);
    check("rd0_cmd_ready", cmd_ready, 1);
    start_cmd(1'b1, 9'h020, 32'h1234_5678, 4'hF);
    check("b2b_rsp_pulse", rsp_valid, 0);
    check("b2b_rdata_hold", rsp_rdata, 32'h5);
    check("b2b_awvalid", bus.M_AXI_AWVALID, 1);
    trace(4);
    check("b2b_rsp_cycle", rsp_cycle, 3);

    // WREADY four cycles after AWREADY.
    w_delay = 4;
    start_cmd(1'b1, 9'h030, 32'hCAFE_0001, 4'hF);
    trace(8);
    check("wdly_awvalid", tr_aw, 16'h0002);
    check("wdly_wvalid", tr_w, 16'h003E);
    check("wdly_bready", tr_b, 16'h0040);
    check("wdly_rsp_cycle", rsp_cycle, 7);
    check("wdly_rsp_count", rsp_count, 1);
    w_delay = 0;

    // Read 0x008 with RVALID three cycles late.
    r_delay = 3; r_force = 1; r_force_data = 32'hDEAD_BEEF;
    start_cmd(1'b0, 9'h008, '0, '0);
    trace(8);
    check("rdly_rready", tr_r, 16'h003C);
    check("rdly_rsp_cycle", rsp_cycle, 6);
    check("rdly_rdata", rsp_d, 32'hDEAD_BEEF);
    check("rdly_resp", {rsp_t, rsp_r}, 0);
    r_delay = 0; r_force = 0;

    // Slave never accepts AR: abort after 8 cycles.
    ar_never = 1;
    start_cmd(1'b0, 9'h004, '0, '0);
    trace(10);
    check("to_arvalid", tr_ar, 16'h01FE);
    check("to_rsp_cycle", rsp_cycle, 9);
    check("to_rsp_count", rsp_count, 1);
    check("to_resp", rsp_r, 2'b10);
    check("to_flag", rsp_t, 1);
    check("to_rdata", rsp_d, 0);
    check("to_cmd_ready", tr_rdy, 16'h0600);
    check("to_hold", {rsp_valid, rsp_timeout, rsp_resp}, 4'b0110);
    ar_never = 0;

    // Slave error response on a write.
    b_resp_cfg = 2'b10;
    start_cmd(1'b1, 9'h040, 32'h0000_00AA, 4'hF);
    trace(4);
    check("berr_rsp_cycle", rsp_cycle, 3);
    check("berr_resp", rsp_r, 2'b10);
    check("berr_timeout", rsp_t, 0);
    b_resp_cfg = 2'b00;

    // Asynchronous reset while waiting in RD_RESP.
    r_delay = 6;
    start_cmd(1'b0, 9'h014, '0, '0);
    trace(2);
    check("arst_in_rd_resp", tr_r, 16'h0004);
    #2 rst = 1'b1;
    #1;
    check("arst_rready", bus.M_AXI_RREADY, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
    check("arst_araddr", bus.M_AXI_ARADDR, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r_delay = 0;
    trace(4);
    check("arst_no_rsp", rsp_count, 0);
    start_cmd(1'b0, 9'h014, '0, '0);
    trace(4);
    check("post_rst_rsp_cycle", rsp_cycle, 3);
    check("post_rst_rdata", rsp_d, 32'h5);
    check("post_rst_resp", {rsp_t, rsp_r}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
